// File: rtl/multicycle_control_fsm_pkg.sv
// rtl/multicycle_control_fsm_pkg.sv - shared encodings for the multi-cycle RISC-V control FSM
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Coarse instruction class; selects the FSM path after EXEC.
  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_ALU     = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4
  } instr_class_e;

endpackage

// File: rtl/multicycle_control_fsm_alu_op_decode.sv
// rtl/multicycle_control_fsm_alu_op_decode.sv - combinational IR decode to ALU controls and legality
module alu_op_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0]  ir,
  output logic [3:0]   operation,
  output logic         alu_src,
  output logic         legal,
  output instr_class_e cls
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_ir_fields;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign unused_ir_fields = ^{ir[24:15], ir[11:7]};

  always_comb begin
    operation = ALU_ADD;
    alu_src   = 1'b0;
    legal     = 1'b0;
    cls       = CLS_ILLEGAL;
    case (opcode)
      OPC_RTYPE: begin
        cls   = CLS_ALU;
        legal = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  operation = ALU_ADD;
            3'b111:  operation = ALU_AND;
            3'b110:  operation = ALU_OR;
            default: legal = 1'b0;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          operation = ALU_SUB;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_IALU: begin
        cls     = CLS_ALU;
        alu_src = 1'b1;
        legal   = 1'b1;
        case (funct3)
          3'b000:  operation = ALU_ADD;
          3'b111:  operation = ALU_AND;
          3'b110:  operation = ALU_OR;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        cls     = CLS_LOAD;
        alu_src = 1'b1;
        legal   = 1'b1;
      end
      OPC_STORE: begin
        cls     = CLS_STORE;
        alu_src = 1'b1;
        legal   = 1'b1;
      end
      OPC_BRANCH: begin
        cls       = CLS_BRANCH;
        operation = ALU_SUB;
        legal     = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // An unsupported funct inside a known opcode is just as illegal as a bad opcode.
    if (!legal) begin
      cls       = CLS_ILLEGAL;
      operation = ALU_ADD;
      alu_src   = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with trap and retire counter
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter logic [63:0] TRAP_VEC = 64'h0000_0000_0000_0040,
  parameter int          CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [31:0]      Instruction,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             Jump,
  output logic [63:0]      NewPC,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [3:0]       Operation,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             MemToReg,
  output logic             Illegal,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] RetireCount
);

  state_e           state_q;
  state_e           state_d;
  logic [31:0]      ir_q;
  logic [CNT_W-1:0] retire_q;

  logic [3:0]   dec_operation;
  logic         dec_alu_src;
  logic         dec_legal;
  instr_class_e dec_cls;

  logic       pc_write;
  logic       jump;
  logic       reg_write;
  logic       alu_src;
  logic [3:0] operation;
  logic       mem_write;
  logic       mem_read;
  logic       mem_to_reg;
  logic       illegal;
  logic       unused_zero;

  // Zero steers the branch target in the datapath; the sequencer does not need it.
  assign unused_zero = Zero;

  alu_op_decode u_alu_op_decode (
    .ir        (ir_q),
    .operation (dec_operation),
    .alu_src   (dec_alu_src),
    .legal     (dec_legal),
    .cls       (dec_cls)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_FETCH;
      ir_q     <= '0;
      retire_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH && Run) begin
        ir_q <= Instruction;
      end
      if (pc_write && !jump) begin
        retire_q <= retire_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = Run ? ST_DECODE : ST_FETCH;
      ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        case (dec_cls)
          CLS_ALU:              state_d = ST_WB;
          CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
          default:              state_d = ST_FETCH;
        endcase
      end
      ST_MEM:    state_d = (dec_cls == CLS_LOAD) ? ST_WB : ST_FETCH;
      ST_WB:     state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Moore outputs: ALU controls stay valid from EXEC through WB so the datapath result is stable.
  always_comb begin
    pc_write   = 1'b0;
    jump       = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    operation  = 4'b0000;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      ST_EXEC: begin
        operation = dec_operation;
        alu_src   = dec_alu_src;
        pc_write  = (dec_cls == CLS_BRANCH);
      end
      ST_MEM: begin
        operation = dec_operation;
        alu_src   = dec_alu_src;
        mem_read  = (dec_cls == CLS_LOAD);
        mem_write = (dec_cls == CLS_STORE);
        pc_write  = (dec_cls == CLS_STORE);
      end
      ST_WB: begin
        operation  = dec_operation;
        alu_src    = dec_alu_src;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = (dec_cls != CLS_LOAD);
      end
      ST_TRAP: begin
        jump     = 1'b1;
        pc_write = 1'b1;
        illegal  = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite     = pc_write;
  assign Jump        = jump;
  assign NewPC       = jump ? TRAP_VEC : 64'd0;
  assign RegWrite    = reg_write;
  assign ALUSrc      = alu_src;
  assign Operation   = operation;
  assign MemWrite    = mem_write;
  assign MemRead     = mem_read;
  assign MemToReg    = mem_to_reg;
  assign Illegal     = illegal;
  assign State       = state_q;
  assign RetireCount = retire_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - randomized self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

  localparam int          CW   = 8;
  localparam logic [63:0] TVEC = 64'h0000_0000_0000_0040;
  localparam logic [31:0] ADD_X5 = 32'h007302B3;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Run = 1'b0;
  logic [31:0]   Instruction = '0;
  logic          Zero = 1'b0;
  logic          PCWrite, Jump, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Illegal;
  logic [63:0]   NewPC;
  logic [3:0]    Operation;
  logic [2:0]    State;
  logic [CW-1:0] RetireCount;

  multicycle_control_fsm #(.TRAP_VEC(TVEC), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Instruction(Instruction), .Zero(Zero),
    .PCWrite(PCWrite), .Jump(Jump), .NewPC(NewPC), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .Operation(Operation), .MemWrite(MemWrite), .MemRead(MemRead), .MemToReg(MemToReg),
    .Illegal(Illegal), .State(State), .RetireCount(RetireCount)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        pcw, jump, regw, alusrc;
    logic [3:0]  op;
    logic        memw, memr, m2r, ill;
    logic [63:0] newpc;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   mcount = 0;

  function automatic obs_t sample_obs();
    obs_t o;
    o.st = State; o.pcw = PCWrite; o.jump = Jump; o.regw = RegWrite; o.alusrc = ALUSrc;
    o.op = Operation; o.memw = MemWrite; o.memr = MemRead; o.m2r = MemToReg;
    o.ill = Illegal; o.newpc = NewPC;
    return o;
  endfunction

  // Expected per-clock trace from FETCH entry; returns 1 when the instruction retires.
  function automatic bit model_trace(input logic [31:0] ins);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [3:0] op;
    logic       src, legal, is_ld, is_st, is_br;
    obs_t       e;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    op = 4'b0010; src = 1'b0; legal = 1'b0;
    is_ld = (opc == 7'h03); is_st = (opc == 7'h23); is_br = (opc == 7'h63);
    if (opc == 7'h33) begin
      legal = 1'b1;
      if (f7 == 7'h00 && f3 == 3'd0) op = 4'b0010;
      else if (f7 == 7'h20 && f3 == 3'd0) op = 4'b0110;
      else if (f7 == 7'h00 && f3 == 3'd7) op = 4'b0000;
      else if (f7 == 7'h00 && f3 == 3'd6) op = 4'b0001;
      else legal = 1'b0;
    end else if (opc == 7'h13) begin
      legal = 1'b1; src = 1'b1;
      if (f3 == 3'd0) op = 4'b0010;
      else if (f3 == 3'd7) op = 4'b0000;
      else if (f3 == 3'd6) op = 4'b0001;
      else legal = 1'b0;
    end else if (is_ld || is_st) begin
      legal = 1'b1; src = 1'b1;
    end else if (is_br) begin
      legal = 1'b1; op = 4'b0110;
    end
    exp_q.delete();
    e = '0;
    exp_q.push_back(e);
    e.st = 3'd1;
    exp_q.push_back(e);
    if (!legal) begin
      e = '0; e.st = 3'd5; e.pcw = 1'b1; e.jump = 1'b1; e.ill = 1'b1; e.newpc = TVEC;
      exp_q.push_back(e);
      return 1'b0;
    end
    e = '0; e.st = 3'd2; e.op = op; e.alusrc = src; e.pcw = is_br;
    exp_q.push_back(e);
    if (is_br) return 1'b1;
    if (is_ld || is_st) begin
      e.st = 3'd3; e.memr = is_ld; e.memw = is_st; e.pcw = is_st;
      exp_q.push_back(e);
      if (is_st) return 1'b1;
      e.memr = 1'b0;
    end
    e.st = 3'd4; e.regw = 1'b1; e.pcw = 1'b1; e.m2r = !is_ld;
    exp_q.push_back(e);
    return 1'b1;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rs1, rs2, rd;
    int         k;
    k = $urandom_range(0, 9);
    rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
    f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(6, 8) % 8);
    f7 = ($urandom_range(0, 4) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
    case (k)
      0, 1, 2: opc = 7'h33;
      3, 4:    opc = 7'h13;
      5:       opc = 7'h03;
      6:       opc = 7'h23;
      7:       opc = 7'h63;
      8:       opc = 7'($urandom);
      default: return $urandom;
    endcase
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  // Drives one instruction from a FETCH negedge and records one sample per clock until FETCH returns.
  task automatic exec_instr(input logic [31:0] ins);
    Instruction = ins;
    Run = 1'b1;
    Zero = 1'($urandom);
    obs_q.delete();
    obs_q.push_back(sample_obs());
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); @(negedge Clk);
      if (State == 3'd0) break;
      obs_q.push_back(sample_obs());
    end
  endtask

  task automatic test_reset();
    Run = 1'b1;
    Instruction = ADD_X5;
    repeat (2) @(negedge Clk);
    if (sample_obs() !== obs_t'(0)) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", sample_obs());
    end
    n_cmp++;
    if (RetireCount !== '0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", RetireCount);
    end
    n_cmp++;
    Run = 1'b0;
    Reset = 1'b1;
    @(posedge Clk); @(negedge Clk);
    if (State !== 3'd0) begin
      n_fail++; $display("FAIL idle_hold: got state %0d want 0", State);
    end
    n_cmp++;
  endtask

  task automatic test_add();
    bit r;
    exec_instr(ADD_X5);
    r = model_trace(ADD_X5);
    if (r) mcount++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL add_len: got %0d cycles want %0d", obs_q.size(), exp_q.size());
    end
    n_cmp++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL add_cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
      n_cmp++;
    end
    if (obs_q.size() != 4 || obs_q[3].st !== 3'd4 || obs_q[3].regw !== 1'b1 || obs_q[3].m2r !== 1'b1 ||
        obs_q[3].op !== 4'b0010 || obs_q[3].pcw !== 1'b1) begin
      n_fail++; $display("FAIL add_wb: got size %0d last %h", obs_q.size(), obs_q[obs_q.size()-1]);
    end
    n_cmp++;
    if (RetireCount !== CW'(1)) begin
      n_fail++; $display("FAIL add_retire: got %0d want 1", RetireCount);
    end
    n_cmp++;
  endtask

  task automatic test_load_store();
    logic [31:0] prog [2];
    bit          r;
    prog[0] = 32'h00003283;
    prog[1] = 32'h00503023;
    for (int p = 0; p < 2; p++) begin
      exec_instr(prog[p]);
      r = model_trace(prog[p]);
      if (r) mcount++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL ldst%0d_len: got %0d want %0d", p, obs_q.size(), exp_q.size());
      end
      n_cmp++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL ldst%0d_cyc%0d: got %h want %h", p, i, obs_q[i], exp_q[i]);
        end
        n_cmp++;
      end
      if (RetireCount !== CW'(mcount)) begin
        n_fail++; $display("FAIL ldst%0d_retire: got %0d want %0d", p, RetireCount, CW'(mcount));
      end
      n_cmp++;
    end
    if (obs_q.size() != 4 || obs_q[3].memw !== 1'b1 || obs_q[3].pcw !== 1'b1 || obs_q[3].regw !== 1'b0) begin
      n_fail++; $display("FAIL store_mem: got size %0d last %h", obs_q.size(), obs_q[obs_q.size()-1]);
    end
    n_cmp++;
  endtask

  task automatic test_beq();
    bit r;
    exec_instr(32'h00630463);
    r = model_trace(32'h00630463);
    if (r) mcount++;
    if (obs_q.size() != 3 || obs_q[2].op !== 4'b0110 || obs_q[2].alusrc !== 1'b0 || obs_q[2].pcw !== 1'b1 ||
        obs_q[2].regw !== 1'b0 || obs_q[2].memw !== 1'b0 || obs_q[2].memr !== 1'b0) begin
      n_fail++; $display("FAIL beq_exec: got size %0d last %h", obs_q.size(), obs_q[obs_q.size()-1]);
    end
    n_cmp++;
    if (RetireCount !== CW'(mcount)) begin
      n_fail++; $display("FAIL beq_retire: got %0d want %0d", RetireCount, CW'(mcount));
    end
    n_cmp++;
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2];
    bit          r;
    bad[0] = 32'h0000007F;
    bad[1] = 32'h007312B3;
    for (int p = 0; p < 2; p++) begin
      exec_instr(bad[p]);
      r = model_trace(bad[p]);
      if (r) mcount++;
      if (obs_q.size() != 3 || obs_q[2] !== exp_q[2] || obs_q[2].jump !== 1'b1 || obs_q[2].newpc !== TVEC ||
          obs_q[2].ill !== 1'b1) begin
        n_fail++; $display("FAIL illegal%0d_trap: got size %0d last %h", p, obs_q.size(), obs_q[obs_q.size()-1]);
      end
      n_cmp++;
      if (RetireCount !== CW'(mcount)) begin
        n_fail++; $display("FAIL illegal%0d_retire: got %0d want %0d", p, RetireCount, CW'(mcount));
      end
      n_cmp++;
    end
  endtask

  task automatic test_run_drop();
    bit r;
    Instruction = ADD_X5;
    Run = 1'b1;
    obs_q.delete();
    obs_q.push_back(sample_obs());
    @(posedge Clk); @(negedge Clk);
    obs_q.push_back(sample_obs());
    Run = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); @(negedge Clk);
      if (State == 3'd0) break;
      obs_q.push_back(sample_obs());
    end
    r = model_trace(ADD_X5);
    if (r) mcount++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rundrop_len: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    n_cmp++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rundrop_cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
      n_cmp++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); @(negedge Clk);
      if (State !== 3'd0 || PCWrite !== 1'b0) begin
        n_fail++; $display("FAIL rundrop_idle%0d: got state %0d pcwrite %0b want 0 0", i, State, PCWrite);
      end
      n_cmp++;
    end
    if (RetireCount !== CW'(mcount)) begin
      n_fail++; $display("FAIL rundrop_retire: got %0d want %0d", RetireCount, CW'(mcount));
    end
    n_cmp++;
  endtask

  task automatic test_random();
    logic [31:0] ins;
    bit          r;
    for (int n = 0; n < 500; n++) begin
      ins = rand_instr();
      exec_instr(ins);
      r = model_trace(ins);
      if (r) mcount++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_len: ins %h got %0d want %0d", n, ins, obs_q.size(), exp_q.size());
      end
      n_cmp++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand%0d_cyc%0d: ins %h got %h want %h", n, i, ins, obs_q[i], exp_q[i]);
        end
        n_cmp++;
      end
      if (RetireCount !== CW'(mcount)) begin
        n_fail++; $display("FAIL rand%0d_retire: got %0d want %0d", n, RetireCount, CW'(mcount));
      end
      n_cmp++;
    end
  endtask

  task automatic test_reset_mid_exec();
    Instruction = ADD_X5;
    Run = 1'b1;
    @(posedge Clk); @(negedge Clk);
    @(posedge Clk); @(negedge Clk);
    if (State !== 3'd2) begin
      n_fail++; $display("FAIL abort_setup: got state %0d want 2", State);
    end
    n_cmp++;
    #2 Reset = 1'b0;
    #1;
    if (sample_obs() !== obs_t'(0) || RetireCount !== '0) begin
      n_fail++; $display("FAIL abort_async: got %h count %0d want 0 0", sample_obs(), RetireCount);
    end
    n_cmp++;
    @(posedge Clk); #1;
    if (sample_obs() !== obs_t'(0) || RetireCount !== '0) begin
      n_fail++; $display("FAIL abort_hold: got %h count %0d want 0 0", sample_obs(), RetireCount);
    end
    n_cmp++;
    @(negedge Clk);
    Reset = 1'b1;
    mcount = 0;
    @(posedge Clk); @(negedge Clk);
    if (State !== 3'd1) begin
      n_fail++; $display("FAIL abort_restart: got state %0d want 1", State);
    end
    n_cmp++;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); @(negedge Clk);
      if (State == 3'd0) break;
    end
    mcount++;
    if (State !== 3'd0 || RetireCount !== CW'(mcount)) begin
      n_fail++; $display("FAIL abort_complete: got state %0d count %0d want 0 %0d", State, RetireCount, mcount);
    end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_store();
    test_beq();
    test_illegal();
    test_run_drop();
    test_random();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
